// File: rtl/periph_bus_ctrl.sv
// Peripheral interconnect: decodes a fixed address window into NUM_SLV slots and runs a
// registered request/ready handshake with slave wait states, bus timeout and an error counter.
module periph_bus_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              NUM_SLV     = 4,
  parameter int              IDX_LSB     = 12,
  parameter logic [XLEN-1:0] PERIPH_BASE = 32'h8000_0000,
  parameter int              TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         cpu_addr,
  input  logic                    cpu_rd_en,
  input  logic                    cpu_wr_en,
  input  logic [XLEN-1:0]         cpu_wr_data,
  input  logic [XLEN/8-1:0]       cpu_be,
  output logic                    periph_hit,
  output logic [XLEN-1:0]         cpu_rd_data,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [7:0]              err_count,
  output logic [NUM_SLV-1:0]      slv_sel,
  output logic [IDX_LSB-1:0]      slv_addr,
  output logic [XLEN-1:0]         slv_wr_data,
  output logic [XLEN/8-1:0]       slv_be,
  output logic                    slv_wr_en,
  output logic                    slv_rd_en,
  input  logic [NUM_SLV*XLEN-1:0] slv_rd_data,
  input  logic [NUM_SLV-1:0]      slv_ready
);

  localparam int              IW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int              BW       = XLEN / 8;
  localparam logic [XLEN:0]   WIN_SIZE = (XLEN+1)'(NUM_SLV) << IDX_LSB;
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [IW-1:0]      idx;
    logic [IDX_LSB-1:0] off;
    logic [XLEN-1:0]    wdata;
    logic [BW-1:0]      be;
    logic               wr;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        errc_d;

  logic [XLEN-1:0]   addr_off;
  logic              hit_raw;
  logic [NUM_SLV-1:0] sel_dec;
  logic              sel_ready;
  logic [XLEN-1:0]   sel_rdata;

  // Base is window-aligned, so the low bits of the offset equal the low address bits.
  assign addr_off   = cpu_addr - PERIPH_BASE;
  assign hit_raw    = (cpu_addr >= PERIPH_BASE) && ({1'b0, addr_off} < WIN_SIZE);
  assign periph_hit = hit_raw & ~rst;

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_slot
    assign sel_dec[k] = (req_q.idx == IW'(k));
  end

  assign sel_ready = |(slv_ready & sel_dec);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++)
      if (sel_dec[k]) sel_rdata = sel_rdata | slv_rd_data[k*XLEN +: XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_count <= errc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    errc_d      = err_count;
    slv_sel     = '0;
    slv_addr    = '0;
    slv_wr_data = '0;
    slv_be      = '0;
    slv_wr_en   = 1'b0;
    slv_rd_en   = 1'b0;
    cpu_ready   = 1'b0;
    cpu_rd_data = '0;
    cpu_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_raw && (cpu_rd_en ^ cpu_wr_en)) begin
          req_d.idx   = addr_off[IDX_LSB +: IW];
          req_d.off   = addr_off[IDX_LSB-1:0];
          req_d.wdata = cpu_wr_data;
          req_d.be    = cpu_be;
          req_d.wr    = cpu_wr_en;
          cnt_d       = '0;
          state_d     = ACCESS;
        end else if (hit_raw && cpu_rd_en && cpu_wr_en) begin
          // Ambiguous direction: answer with an error without touching any slave.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ACCESS: begin
        slv_sel     = sel_dec;
        slv_addr    = req_q.off;
        slv_wr_data = req_q.wdata;
        slv_be      = req_q.be;
        slv_wr_en   = req_q.wr;
        slv_rd_en   = ~req_q.wr;
        if (sel_ready) begin
          rdata_d = req_q.wr ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        cpu_ready   = 1'b1;
        cpu_rd_data = rdata_q;
        cpu_err     = err_q;
        if (err_q && err_count != 8'hFF) errc_d = err_count + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/periph_bus_ctrl.md
Name: periph_bus_ctrl

Overview:
Parametrised memory-mapped peripheral interconnect between the rv_core data port and NUM_SLV peripheral slots (UART, GPIO, SPI, ...). It replaces the single-peripheral combinational address decode with a registered request/ready handshake, variable slave wait states, a bus-timeout error and an error counter. Accesses outside the peripheral window are flagged combinationally so the top level routes them to data RAM.

Parameters:
XLEN, 32, data/address width
NUM_SLV, 4, number of peripheral slots (1..16)
IDX_LSB, 12, log2 of slot size in bytes; slot offset width
PERIPH_BASE, 32'h8000_0000, window base (aligned to NUM_SLV<<IDX_LSB)
TIMEOUT, 255, max ACCESS cycles before bus error (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cpu_addr  in  XLEN  byte address from core
cpu_rd_en  in  1  read request, held until cpu_ready
cpu_wr_en  in  1  write request, held until cpu_ready
cpu_wr_data  in  XLEN  write data
cpu_be  in  XLEN/8  byte enables
periph_hit  out  1  combinational: cpu_addr inside window
cpu_rd_data  out  XLEN  read data, valid while cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  error qualifier, valid while cpu_ready
err_count  out  8  saturating count of error responses
slv_sel  out  NUM_SLV  one-hot slot select
slv_addr  out  IDX_LSB  offset inside slot
slv_wr_data  out  XLEN  registered write data
slv_be  out  XLEN/8  registered byte enables
slv_wr_en  out  1  write strobe
slv_rd_en  out  1  read strobe
slv_rd_data  in  NUM_SLV*XLEN  flattened per-slot read data, slot k at [k*XLEN +: XLEN]
slv_ready  in  NUM_SLV  per-slot completion

Behaviour:
- Hit: periph_hit = (cpu_addr >= PERIPH_BASE) && (cpu_addr < PERIPH_BASE + (NUM_SLV<<IDX_LSB)). Index = (cpu_addr - PERIPH_BASE) >> IDX_LSB; offset = cpu_addr[IDX_LSB-1:0].
- Reset values: state IDLE; every output 0; err_count 0; timeout counter 0. Async assertion aborts any transaction immediately, no response issued.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: if periph_hit and exactly one of rd_en/wr_en: latch index, offset, data, be, direction; clear counter; -> ACCESS. If periph_hit and both asserted: -> RESP with err=1, no slave access. Miss: stay IDLE.
- ACCESS: slv_sel[index]=1, slv_addr/slv_wr_data/slv_be from latches, slv_wr_en or slv_rd_en held high every cycle. If slv_ready[index]=1: capture slot read data (0 for writes), err=0, -> RESP. Else counter+1; when counter reaches TIMEOUT-1 without ready: rd_data=0, err=1, -> RESP. slv_ready of unselected slots ignored.
- RESP: all slave strobes/sel 0; cpu_ready=1, cpu_rd_data and cpu_err driven from registers for exactly this cycle; err_count += cpu_err, saturating at 255; -> IDLE. Outside RESP cpu_ready=0, cpu_rd_data=0, cpu_err=0.
- Latency: zero-wait slave = request in cycle N, ACCESS N+1, cpu_ready N+2. Each slave wait cycle adds one. Timeout: cpu_ready exactly TIMEOUT+1 cycles after the request cycle.
- Back-to-back: the IDLE cycle following RESP samples the next request (core must drop or change its request after ready).
- cpu_addr/data changes during ACCESS have no effect (latched).

Test Plan:
- Write 32'hA5A5_0001 to 32'h8000_1004, be=4'hF, slot1 ready immediately -> slv_sel=4'b0010, slv_addr=12'h004, slv_wr_en 1 cycle, cpu_ready at cycle+2, cpu_err=0.
- Read 32'h8000_3010, slot3 ready after 3 wait cycles returning 32'h1234_5678 -> cpu_ready at cycle+5, cpu_rd_data=32'h1234_5678, err_count=0.
- Read 32'h8000_2000, slot2 never ready, TIMEOUT=255 -> cpu_ready at cycle+256, cpu_err=1, cpu_rd_data=0, err_count=1.
- cpu_addr=32'h0000_0100 read -> periph_hit=0, no slv_sel, no cpu_ready; cpu_addr=32'h8000_4000 (NUM_SLV=4) -> periph_hit=0.
- rd_en and wr_en both high at 32'h8000_0000 -> no slave strobe, cpu_ready at cycle+1 with cpu_err=1; repeat 300 times -> err_count stays 255.
- Assert rst during ACCESS with slot0 pending -> all outputs 0 same cycle, no cpu_ready after release, next request served normally.
